cv32e40p_load_store_unit: RTL and testbench

CV32E40P_LOAD_STORE_UNIT -- requirements
Module: cv32e40p_load_store_unit

---
 rtl/cv32e40p_load_store_unit_pkg.sv | 34 +++
 rtl/cv32e40p_load_store_unit_if.sv | 24 ++
 rtl/cv32e40p_lsu_rdata_ext.sv | 25 ++
 rtl/cv32e40p_load_store_unit.sv | 127 ++++++++++++
 tb/tb_cv32e40p_load_store_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_load_store_unit_pkg.sv
// Shared LSU definitions: access-size encodings and lane/byte-enable helpers.
package cv32e40p_pkg;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    function automatic logic [3:0] lsu_be(input logic [1:0] dtype, input logic [1:0] offs);
        case (dtype)
            BYTE:    return 4'b0001 << offs;
            HALF:    return offs[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [1:0] dtype, input logic [31:0] wdata);
        case (dtype)
            BYTE:    return {4{wdata[7:0]}};
            HALF:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Reserved size encoding is rejected the same way as a misaligned access.
    function automatic logic lsu_misaligned(input logic [1:0] dtype, input logic [1:0] offs);
        case (dtype)
            BYTE:    return 1'b0;
            HALF:    return offs[0];
            WORD:    return offs != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40p_load_store_unit_if.sv
// OBI data-bus bundle between the LSU (master) and memory (slave).
interface cv32e40p_load_store_unit_if;

    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_addr_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

endinterface

// File: rtl/cv32e40p_lsu_rdata_ext.sv
// Load-data alignment: shift the addressed lane down and sign/zero-extend to 32 bits.
module cv32e40p_lsu_rdata_ext
    import cv32e40p_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offs_i,
    input  logic [1:0]  type_i,
    input  logic        sign_ext_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offs_i, 3'b000};

    always_comb begin
        rdata_o = shifted;
        case (type_i)
            BYTE:    rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            HALF:    rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/cv32e40p_load_store_unit.sv
// Single-outstanding OBI load/store unit. Define CV32E40P_LSU_BUS_ERR_EN to report bus errors.
module cv32e40p_load_store_unit
    import cv32e40p_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            data_req_ex_i,
    input  logic                            data_we_ex_i,
    input  logic [1:0]                      data_type_ex_i,
    input  logic                            data_sign_ext_ex_i,
    input  logic [31:0]                     operand_a_ex_i,
    input  logic [31:0]                     operand_b_ex_i,
    input  logic [31:0]                     data_wdata_ex_i,
    output logic                            lsu_ready_o,
    output logic [31:0]                     lsu_rdata_o,
    output logic                            lsu_rvalid_o,
    output logic                            lsu_misaligned_o,
    output logic                            lsu_err_o,
    cv32e40p_load_store_unit_if.master      obi
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_ex, wdata_ex, rdata_ext;
    logic [3:0]  be_ex;
    logic        accept, misaligned, accept_ok, resp, bus_err;

    logic        we_q, sign_ext_q, rvalid_q, misaligned_q, err_q;
    logic [3:0]  be_q;
    logic [1:0]  type_q, offs_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    assign addr_ex    = operand_a_ex_i + operand_b_ex_i;
    assign be_ex      = lsu_be(data_type_ex_i, addr_ex[1:0]);
    assign wdata_ex   = lsu_wdata(data_type_ex_i, data_wdata_ex_i);
    assign misaligned = lsu_misaligned(data_type_ex_i, addr_ex[1:0]);
    assign accept     = data_req_ex_i & lsu_ready_o;
    assign accept_ok  = accept & ~misaligned;
    assign resp       = (state_q == WAIT_RVALID) & obi.data_rvalid_i;

`ifdef CV32E40P_LSU_BUS_ERR_EN
    assign bus_err = obi.data_err_i;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (accept_ok) state_d = obi.data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            WAIT_GNT:    if (obi.data_gnt_i) state_d = WAIT_RVALID;
            WAIT_RVALID: if (obi.data_rvalid_i) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // In IDLE the bus sees the live request; afterwards it is replayed from the latched copy.
    always_comb begin
        lsu_ready_o      = (state_q == IDLE);
        obi.data_req_o   = 1'b0;
        obi.data_we_o    = we_q;
        obi.data_addr_o  = addr_q;
        obi.data_be_o    = be_q;
        obi.data_wdata_o = wdata_q;
        case (state_q)
            IDLE: begin
                obi.data_req_o   = accept_ok;
                obi.data_we_o    = data_we_ex_i;
                obi.data_addr_o  = {addr_ex[31:2], 2'b00};
                obi.data_be_o    = be_ex;
                obi.data_wdata_o = wdata_ex;
            end
            WAIT_GNT: obi.data_req_o = 1'b1;
            default:  ;
        endcase
    end

    cv32e40p_lsu_rdata_ext u_rdata_ext (
        .rdata_i    (obi.data_rdata_i),
        .offs_i     (offs_q),
        .type_i     (type_q),
        .sign_ext_i (sign_ext_q),
        .rdata_o    (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            sign_ext_q   <= 1'b0;
            be_q         <= '0;
            type_q       <= '0;
            offs_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            misaligned_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (accept_ok) begin
                we_q       <= data_we_ex_i;
                sign_ext_q <= data_sign_ext_ex_i;
                be_q       <= be_ex;
                type_q     <= data_type_ex_i;
                offs_q     <= addr_ex[1:0];
                addr_q     <= {addr_ex[31:2], 2'b00};
                wdata_q    <= wdata_ex;
            end
            if (resp & ~we_q & ~bus_err) rdata_q <= rdata_ext;
            rvalid_q     <= resp;
            err_q        <= resp & bus_err;
            misaligned_q <= accept & misaligned;
        end
    end

    assign lsu_rdata_o      = rdata_q;
    assign lsu_rvalid_o     = rvalid_q;
    assign lsu_misaligned_o = misaligned_q;
    assign lsu_err_o        = err_q;

endmodule

// File: tb/tb_cv32e40p_load_store_unit.sv
// Directed bench for the LSU with a scoreboard of expected completions.
module tb_cv32e40p_load_store_unit;
    import cv32e40p_pkg::*;

`ifdef CV32E40P_LSU_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_ex_i, data_we_ex_i, data_sign_ext_ex_i;
    logic [1:0]  data_type_ex_i;
    logic [31:0] operand_a_ex_i, operand_b_ex_i, data_wdata_ex_i;
    logic        lsu_ready_o, lsu_rvalid_o, lsu_misaligned_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;

    cv32e40p_load_store_unit_if obi();

    cv32e40p_load_store_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_req_ex_i      (data_req_ex_i),
        .data_we_ex_i       (data_we_ex_i),
        .data_type_ex_i     (data_type_ex_i),
        .data_sign_ext_ex_i (data_sign_ext_ex_i),
        .operand_a_ex_i     (operand_a_ex_i),
        .operand_b_ex_i     (operand_b_ex_i),
        .data_wdata_ex_i    (data_wdata_ex_i),
        .lsu_ready_o        (lsu_ready_o),
        .lsu_rdata_o        (lsu_rdata_o),
        .lsu_rvalid_o       (lsu_rvalid_o),
        .lsu_misaligned_o   (lsu_misaligned_o),
        .lsu_err_o          (lsu_err_o),
        .obi                (obi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_rdata;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Registered outputs are stable at the falling edge; completions are popped here.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (lsu_rvalid_o) begin
            if (sb_q.size() == 0) chk("sb_unexpected_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("sb_rdata", lsu_rdata_o, e.rdata);
                chk("sb_err", {31'b0, lsu_err_o}, {31'b0, e.err});
            end
        end else begin
            chk("err_without_rvalid", {31'b0, lsu_err_o}, 32'd0);
        end
    endtask

    task automatic push_exp(input logic we, input logic [31:0] val, input logic err);
        exp_t e;
        if (!we && !(err && ERR_EN)) model_rdata = val;
        e.rdata = model_rdata;
        e.err   = err & ERR_EN;
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] dt, input logic sx,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd);
        data_req_ex_i      = 1'b1;
        data_we_ex_i       = we;
        data_type_ex_i     = dt;
        data_sign_ext_ex_i = sx;
        operand_a_ex_i     = a;
        operand_b_ex_i     = b;
        data_wdata_ex_i    = wd;
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [1:0] dt, input logic sx,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                          input logic err, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_val);
        drive_req(we, dt, sx, a, b, wd);
        obi.data_gnt_i = (gnt_dly == 0);
        #1;
        chk({tag, "_req"}, {31'b0, obi.data_req_o}, 32'd1);
        chk({tag, "_addr"}, obi.data_addr_o, exp_addr);
        chk({tag, "_be"}, {28'b0, obi.data_be_o}, {28'b0, exp_be});
        chk({tag, "_we"}, {31'b0, obi.data_we_o}, {31'b0, we});
        if (we) chk({tag, "_wdata"}, obi.data_wdata_o, exp_wdata);
        push_exp(we, exp_val, err);
        for (int i = 0; i < gnt_dly; i++) begin
            tick();
            operand_a_ex_i  = $urandom;
            data_wdata_ex_i = $urandom;
            data_type_ex_i  = 2'($urandom_range(0, 2));
            obi.data_gnt_i  = (i == gnt_dly - 1);
            #1;
            chk({tag, "_hold_req"}, {31'b0, obi.data_req_o}, 32'd1);
            chk({tag, "_hold_addr"}, obi.data_addr_o, exp_addr);
            chk({tag, "_hold_be"}, {28'b0, obi.data_be_o}, {28'b0, exp_be});
            if (we) chk({tag, "_hold_wdata"}, obi.data_wdata_o, exp_wdata);
            chk({tag, "_hold_ready"}, {31'b0, lsu_ready_o}, 32'd0);
        end
        tick();
        data_req_ex_i  = 1'b0;
        obi.data_gnt_i = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin
            #1;
            chk({tag, "_rwait_req"}, {31'b0, obi.data_req_o}, 32'd0);
            tick();
        end
        obi.data_rvalid_i = 1'b1;
        obi.data_rdata_i  = rdata;
        obi.data_err_i    = err;
        #1;
        chk({tag, "_resp_req"}, {31'b0, obi.data_req_o}, 32'd0);
        chk({tag, "_resp_ready"}, {31'b0, lsu_ready_o}, 32'd0);
        tick();
        obi.data_rvalid_i = 1'b0;
        obi.data_err_i    = 1'b0;
        chk({tag, "_rvalid"}, {31'b0, lsu_rvalid_o}, 32'd1);
        chk({tag, "_ready_after"}, {31'b0, lsu_ready_o}, 32'd1);
    endtask

    task automatic do_misaligned(input string tag, input logic [1:0] dt,
                                 input logic [31:0] a, input logic [31:0] b);
        drive_req(1'b0, dt, 1'b0, a, b, 32'h0);
        obi.data_gnt_i = 1'b1;
        #1;
        chk({tag, "_no_req"}, {31'b0, obi.data_req_o}, 32'd0);
        tick();
        data_req_ex_i  = 1'b0;
        obi.data_gnt_i = 1'b0;
        chk({tag, "_pulse"}, {31'b0, lsu_misaligned_o}, 32'd1);
        chk({tag, "_ready"}, {31'b0, lsu_ready_o}, 32'd1);
        tick();
        chk({tag, "_pulse_end"}, {31'b0, lsu_misaligned_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        data_req_ex_i = 1'b0; data_we_ex_i = 1'b0; data_type_ex_i = WORD;
        data_sign_ext_ex_i = 1'b0; operand_a_ex_i = '0; operand_b_ex_i = '0;
        data_wdata_ex_i = '0;
        obi.data_gnt_i = 1'b0; obi.data_rvalid_i = 1'b0; obi.data_err_i = 1'b0;
        obi.data_rdata_i = '0;
        model_rdata = '0;
        tick(); tick();
        chk("rst_ready", {31'b0, lsu_ready_o}, 32'd1);
        chk("rst_req", {31'b0, obi.data_req_o}, 32'd0);
        chk("rst_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("rst_misaligned", {31'b0, lsu_misaligned_o}, 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        chk("rst_addr", obi.data_addr_o, 32'd0);
        rst_n = 1'b1;
        tick();

        do_txn("lw", 1'b0, WORD, 1'b0, 32'h1000, 32'h4, '0, 0, 0, 32'hDEADBEEF, 1'b0,
               32'h1004, 4'b1111, '0, 32'hDEADBEEF);
        do_txn("lb", 1'b0, BYTE, 1'b1, 32'h0, 32'h3, '0, 0, 1, 32'h80000000, 1'b0,
               32'h0, 4'b1000, '0, 32'hFFFFFF80);
        do_txn("lbu", 1'b0, BYTE, 1'b0, 32'h0, 32'h3, '0, 0, 0, 32'h80000000, 1'b0,
               32'h0, 4'b1000, '0, 32'h00000080);
        do_txn("sh", 1'b1, HALF, 1'b0, 32'h0, 32'h2, 32'h0000ABCD, 3, 0, 32'h0, 1'b0,
               32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
        do_misaligned("lw_mis", WORD, 32'h1000, 32'h2);
        do_txn("lh", 1'b0, HALF, 1'b1, 32'h4, 32'h2, '0, 1, 0, 32'hBEEF0000, 1'b0,
               32'h4, 4'b1100, '0, 32'hFFFFBEEF);
        do_txn("lhu", 1'b0, HALF, 1'b0, 32'hFFFFFFFC, 32'h8, '0, 0, 2, 32'h12348001, 1'b0,
               32'h4, 4'b0011, '0, 32'h00008001);
        do_txn("lbu1", 1'b0, BYTE, 1'b0, 32'h100, 32'h1, '0, 0, 0, 32'h0000A500, 1'b0,
               32'h100, 4'b0010, '0, 32'h000000A5);
        do_txn("sb", 1'b1, BYTE, 1'b0, 32'h200, 32'h1, 32'hFFFFFF12, 1, 0, 32'h0, 1'b0,
               32'h200, 4'b0010, 32'h12121212, 32'h0);
        do_txn("sw", 1'b1, WORD, 1'b0, 32'h4, 32'h4, 32'hCAFEF00D, 0, 0, 32'h0, 1'b0,
               32'h8, 4'b1111, 32'hCAFEF00D, 32'h0);
        do_misaligned("lh_mis", HALF, 32'h0, 32'h1);
        do_misaligned("rsvd", 2'b11, 32'h0, 32'h0);

        // Reset while waiting for the response; the late response must be dropped.
        drive_req(1'b0, WORD, 1'b0, 32'h40, 32'h0, '0);
        obi.data_gnt_i = 1'b1;
        tick();
        data_req_ex_i  = 1'b0;
        obi.data_gnt_i = 1'b0;
        chk("rstmid_ready_busy", {31'b0, lsu_ready_o}, 32'd0);
        rst_n = 1'b0;
        model_rdata = '0;
        tick();
        chk("rstmid_rdata_cleared", lsu_rdata_o, 32'd0);
        rst_n = 1'b1;
        obi.data_rvalid_i = 1'b1;
        obi.data_rdata_i  = 32'hCAFEBABE;
        #1;
        chk("rstmid_ready_idle", {31'b0, lsu_ready_o}, 32'd1);
        tick();
        obi.data_rvalid_i = 1'b0;
        chk("rstmid_no_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("rstmid_rdata", lsu_rdata_o, 32'd0);

        do_txn("lw_err", 1'b0, WORD, 1'b0, 32'h20, 32'h0, '0, 0, 0, 32'h11223344, 1'b1,
               32'h20, 4'b1111, '0, 32'h11223344);
        chk("err_rdata_model", lsu_rdata_o, model_rdata);
        do_txn("lw_after", 1'b0, WORD, 1'b0, 32'h24, 32'h0, '0, 0, 0, 32'h55667788, 1'b0,
               32'h24, 4'b1111, '0, 32'h55667788);

        // Stray response with nothing outstanding.
        obi.data_rvalid_i = 1'b1;
        obi.data_rdata_i  = 32'h0BADF00D;
        tick();
        obi.data_rvalid_i = 1'b0;
        chk("stray_no_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("stray_rdata", lsu_rdata_o, 32'h55667788);
        tick();

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
